pwm_reg_bank: RTL
=================

# pwm_reg_bank

Register-bank responder for the three-channel PWM peripheral: the target end of the byte-wide host write bus (6-bit address, 8-bit data, write strobe on `ui_in`/`uio_in`). Decodes host writes into per-channel shadow registers, transfers them atomically into active registers at each channel's period boundary, and provides optional byte readback on `uio_out`. It sits between the top-level pin mapping and the three PWM channel cores.

## Interface
- `NUM_CH`, 3: PWM channels; the address map is fixed for 3.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `ena`  in  1: block enable; when low, writes are ignored and `rdata_oe` is 0.
- `wr_en`  in  1: host write strobe (`ui_in[0]`).
- `addr`  in  6: register address (`ui_in[7:2]`).
- `wdata`  in  8: write data (`uio_in`).
- `rdata`  out  8: readback data (`uio_out`).
- `rdata_oe`  out  8: pad output enables (`uio_oe`).
- `load_stb`  in  3: per-channel period-end pulse from the channel counter.
- `ctrl`  out  24: per-channel control byte, ch *n* at bits [8n+7:8n].
- `period`, `phase`, `cmp_aa`, `cmp_ab`, `cmp_ba`, `cmp_bb`  out  48 each: active 16-bit values, ch *n* at [16n+15:16n].
- `act_a`, `act_b`, `db_a`, `db_b`  out  24 each: active action and deadband bytes.
- `pending`  out  3: shadow differs from active for that channel.

## Operation
- Ch0 map, 0x00–0x0E: CTRL, PER_H, PER_L, ACTA, CMPAA_H, CMPAA_L, CMPAB_H, CMPAB_L, DBA, ACTB, CMPBA_H, CMPBA_L, CMPBB_H, CMPBB_L, DBB. Ch0 has no phase register; `phase[15:0]` is constant 0.
- Ch1 map, 0x0F–0x1F: CTRL, PER_H, PER_L, PH_H, PH_L, followed by the same 12 bytes as ch0 (ACTA..DBB).
- Ch2 map, 0x20–0x30: same layout as ch1.
- 0x31–0x3F are unmapped. Writes to them are dropped; reads return 0x00.
- Write: on any edge where `ena & wr_en` is high, `wdata` goes to the addressed register. Holding the strobe for several cycles rewrites the same value, which is harmless.
- CTRL writes go directly to the active register.
- All other registers are written to the shadow copy, and the channel's `pending` bit is set.
- Transfer: on an edge with `load_stb[n]`, or with `ctrl[8n]` (channel enable) equal to 0, the whole shadow set of ch *n* is copied to active and `pending[n]` is cleared.
- Simultaneous write and transfer on the same edge: active takes the pre-write shadow. The new byte lands in shadow and `pending[n]` stays set.
- 16-bit values are assembled as {_H, _L}. No range checking is done; `period` = 0 is passed through unchanged.
- Reset: all shadow and active registers are 0x00, `pending` = 0, `rdata` = 0x00, `rdata_oe` = 0x00.
- Reset mid-write discards the write.

## Timing
- Write at edge N: shadow is updated at N and `pending` is high after N.
- Active update occurs at the first edge ≥ N+1 that has a strobe or the channel disabled. With the channel disabled, active is updated at N+1.
- CTRL write at edge N: `ctrl` output changes after N (1-cycle latency).
- Readback: `rdata` is registered and reflects the shadow at the `addr` sampled one edge earlier.
- Readback direction: `rdata_oe` = 0xFF one cycle after `ena & ~wr_en`, and 0x00 one cycle after `wr_en` rises.

## Configuration
- `PWM_REGBANK_READBACK_EN`:
  - Defined: the readback mux and the `rdata`/`rdata_oe` registers are present as described above.
  - Undefined: `rdata` and `rdata_oe` are tied to 0x00 and the readback mux is not built. Write and transfer behaviour is unchanged.

## Structure
- Shared package `pwm_pkg`:
  - address constants (`CH0_BASE`=0x00, `CH1_BASE`=0x0F, `CH2_BASE`=0x20, `ADDR_LAST`=0x30);
  - per-register offsets;
  - channel config struct/typedef (ctrl, period, phase, 4 compares, 2 actions, 2 deadbands).
- Sub-module `pwm_reg_channel`, instantiated ×3: holds the shadow/active set and `pending` for one channel. It is parameterised by base address and a HAS_PHASE flag (0 for ch0).

## Test plan
- Reset with `rst_n`=0 for 8 cycles → all outputs 0, `pending`=0, `rdata_oe`=0x00.
- Ch0 CTRL=0x17, PER_H=0x00, PER_L=0x1F, with `load_stb`=0 → `ctrl[7:0]`=0x17 next cycle; `period[15:0]` stays 0 and `pending[0]`=1. Pulse `load_stb[0]` → `period[15:0]`=0x001F and `pending[0]`=0.
- Ch1 writes PH_L=0x0A and CMPAA_L=0x08 with CTRL bit0=0 → `phase[31:16]`=0x000A and `cmp_aa[31:16]`=0x0008 one cycle after each write, with no strobe needed.
- Write ch2 CMPBB_L=0x55 on the same edge as `load_stb[2]` → active stays at the old value and `pending[2]`=1. The next strobe makes `cmp_bb[47:32]`=0x0055.
- Write to 0x35 → no register changes. With `PWM_REGBANK_READBACK_EN` defined, reading 0x35 returns 0x00.
- Readback (macro defined): after writing DBA at 0x08 = 0x30, drop `wr_en` and set `addr`=0x08 → `rdata`=0x30 and `rdata_oe`=0xFF one cycle later. With the macro undefined, both outputs stay 0x00.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM register bank: address map, register offsets,
// per-channel configuration record and byte-to-record helpers.
package pwm_pkg;

    localparam int NUM_CH = 3;

    localparam logic [5:0] CH0_BASE  = 6'h00;
    localparam logic [5:0] CH1_BASE  = 6'h0F;
    localparam logic [5:0] CH2_BASE  = 6'h20;
    localparam logic [5:0] ADDR_LAST = 6'h30;

    // Logical offsets within a full (phase-capable) channel block.
    localparam logic [4:0] OFF_CTRL    = 5'd0;
    localparam logic [4:0] OFF_PER_H   = 5'd1;
    localparam logic [4:0] OFF_PER_L   = 5'd2;
    localparam logic [4:0] OFF_PH_H    = 5'd3;
    localparam logic [4:0] OFF_PH_L    = 5'd4;
    localparam logic [4:0] OFF_ACTA    = 5'd5;
    localparam logic [4:0] OFF_CMPAA_H = 5'd6;
    localparam logic [4:0] OFF_CMPAA_L = 5'd7;
    localparam logic [4:0] OFF_CMPAB_H = 5'd8;
    localparam logic [4:0] OFF_CMPAB_L = 5'd9;
    localparam logic [4:0] OFF_DBA     = 5'd10;
    localparam logic [4:0] OFF_ACTB    = 5'd11;
    localparam logic [4:0] OFF_CMPBA_H = 5'd12;
    localparam logic [4:0] OFF_CMPBA_L = 5'd13;
    localparam logic [4:0] OFF_CMPBB_H = 5'd14;
    localparam logic [4:0] OFF_CMPBB_L = 5'd15;
    localparam logic [4:0] OFF_DBB     = 5'd16;

    localparam int         NUM_BYTES    = 17;
    localparam logic [5:0] NREG_PHASE   = 6'd17;
    localparam logic [5:0] NREG_NOPHASE = 6'd15;

    typedef logic [NUM_BYTES-1:0][7:0] ch_bytes_t;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [15:0] period;
        logic [15:0] phase;
        logic [15:0] cmp_aa;
        logic [15:0] cmp_ab;
        logic [15:0] cmp_ba;
        logic [15:0] cmp_bb;
        logic [7:0]  act_a;
        logic [7:0]  act_b;
        logic [7:0]  db_a;
        logic [7:0]  db_b;
    } ch_cfg_t;

    // A channel without phase skips the two PH bytes, so its later offsets shift up by two.
    function automatic logic [4:0] reg_index(input logic [5:0] off, input logic has_phase);
        logic [4:0] idx;
        if (!has_phase && (off >= 6'd3)) begin
            idx = 5'(off + 6'd2);
        end else begin
            idx = 5'(off);
        end
        return idx;
    endfunction

    function automatic ch_cfg_t bytes_to_cfg(input ch_bytes_t b, input logic [7:0] ctrl);
        ch_cfg_t cfg;
        cfg.ctrl   = ctrl;
        cfg.period = {b[OFF_PER_H],   b[OFF_PER_L]};
        cfg.phase  = {b[OFF_PH_H],    b[OFF_PH_L]};
        cfg.cmp_aa = {b[OFF_CMPAA_H], b[OFF_CMPAA_L]};
        cfg.cmp_ab = {b[OFF_CMPAB_H], b[OFF_CMPAB_L]};
        cfg.cmp_ba = {b[OFF_CMPBA_H], b[OFF_CMPBA_L]};
        cfg.cmp_bb = {b[OFF_CMPBB_H], b[OFF_CMPBB_L]};
        cfg.act_a  = b[OFF_ACTA];
        cfg.act_b  = b[OFF_ACTB];
        cfg.db_a   = b[OFF_DBA];
        cfg.db_b   = b[OFF_DBB];
        return cfg;
    endfunction

endpackage

// File: rtl/pwm_reg_channel.sv
// One PWM channel's shadow/active register set: decodes its address window,
// transfers shadow to active at period end or while the channel is disabled.
module pwm_reg_channel
    import pwm_pkg::*;
#(
    parameter logic [5:0] BASE      = 6'h00,
    parameter bit         HAS_PHASE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ena,
    input  logic       i_wr_en,
    input  logic [5:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic       i_load_stb,
    output ch_cfg_t    o_cfg,
    output logic       o_pending,
    output logic [7:0] o_rd_data
);

    localparam logic [5:0] NREG = HAS_PHASE ? NREG_PHASE : NREG_NOPHASE;

    ch_bytes_t  r_shadow;
    ch_cfg_t    r_active;
    logic       r_pending;

    logic [5:0] w_off;
    logic [4:0] w_idx;
    logic       w_hit;
    logic       w_wr_ctrl;
    logic       w_wr_shadow;
    logic       w_xfer;

    // Address decode, write qualification and transfer condition.
    always_comb begin
        w_off       = i_addr - BASE;
        w_hit       = (i_addr >= BASE) && (w_off < NREG);
        w_idx       = reg_index(w_off, HAS_PHASE);
        w_wr_ctrl   = i_ena & i_wr_en & w_hit & (w_idx == OFF_CTRL);
        w_wr_shadow = i_ena & i_wr_en & w_hit & (w_idx != OFF_CTRL);
        w_xfer      = i_load_stb | ~r_active.ctrl[0];
    end

    // Shadow/active/pending state; a transfer copies the pre-write shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_active <= bytes_to_cfg(r_shadow, r_active.ctrl);
            end
            if (w_wr_ctrl) begin
                r_active.ctrl <= i_wdata;
            end
            if (w_wr_shadow) begin
                r_shadow[w_idx] <= i_wdata;
            end
            if (w_wr_shadow) begin
                r_pending <= 1'b1;
            end else if (w_xfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Readback view: CTRL has no shadow, so its active value is returned.
    always_comb begin
        o_rd_data = 8'h00;
        if (w_hit) begin
            if (w_idx == OFF_CTRL) begin
                o_rd_data = r_active.ctrl;
            end else begin
                o_rd_data = r_shadow[w_idx];
            end
        end else begin
            o_rd_data = 8'h00;
        end
    end

    assign o_cfg     = r_active;
    assign o_pending = r_pending;

endmodule

// File: rtl/pwm_reg_bank.sv
// Three-channel PWM register bank responder with shadowed, atomically loaded registers.
// Optional byte readback is built when PWM_REGBANK_READBACK_EN is defined.
module pwm_reg_bank
    import pwm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        wr_en,
    input  logic [5:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic [7:0]  rdata_oe,
    input  logic [2:0]  load_stb,
    output logic [23:0] ctrl,
    output logic [47:0] period,
    output logic [47:0] phase,
    output logic [47:0] cmp_aa,
    output logic [47:0] cmp_ab,
    output logic [47:0] cmp_ba,
    output logic [47:0] cmp_bb,
    output logic [23:0] act_a,
    output logic [23:0] act_b,
    output logic [23:0] db_a,
    output logic [23:0] db_b,
    output logic [2:0]  pending
);

    ch_cfg_t    w_cfg     [NUM_CH];
    logic [7:0] w_rd_data [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [5:0] CH_BASE = (g == 0) ? CH0_BASE : ((g == 1) ? CH1_BASE : CH2_BASE);

        pwm_reg_channel #(
            .BASE      (CH_BASE),
            .HAS_PHASE (g != 0)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_ena      (ena),
            .i_wr_en    (wr_en),
            .i_addr     (addr),
            .i_wdata    (wdata),
            .i_load_stb (load_stb[g]),
            .o_cfg      (w_cfg[g]),
            .o_pending  (pending[g]),
            .o_rd_data  (w_rd_data[g])
        );

        assign ctrl  [8*g  +: 8]  = w_cfg[g].ctrl;
        assign period[16*g +: 16] = w_cfg[g].period;
        assign phase [16*g +: 16] = w_cfg[g].phase;
        assign cmp_aa[16*g +: 16] = w_cfg[g].cmp_aa;
        assign cmp_ab[16*g +: 16] = w_cfg[g].cmp_ab;
        assign cmp_ba[16*g +: 16] = w_cfg[g].cmp_ba;
        assign cmp_bb[16*g +: 16] = w_cfg[g].cmp_bb;
        assign act_a [8*g  +: 8]  = w_cfg[g].act_a;
        assign act_b [8*g  +: 8]  = w_cfg[g].act_b;
        assign db_a  [8*g  +: 8]  = w_cfg[g].db_a;
        assign db_b  [8*g  +: 8]  = w_cfg[g].db_b;
    end

`ifdef PWM_REGBANK_READBACK_EN
    logic [7:0] r_rdata;
    logic [7:0] r_rdata_oe;
    logic [7:0] w_rd_mux;

    // Channel windows are disjoint and non-hits read zero, so OR-ing selects the hit.
    always_comb begin
        w_rd_mux = w_rd_data[0] | w_rd_data[1] | w_rd_data[2];
    end

    // Registered readback data and pad direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata    <= 8'h00;
            r_rdata_oe <= 8'h00;
        end else begin
            r_rdata    <= w_rd_mux;
            r_rdata_oe <= (ena & ~wr_en) ? 8'hFF : 8'h00;
        end
    end

    assign rdata    = r_rdata;
    assign rdata_oe = r_rdata_oe;
`else
    logic w_unused_rd;
    assign w_unused_rd = |(w_rd_data[0] | w_rd_data[1] | w_rd_data[2]);
    assign rdata       = 8'h00;
    assign rdata_oe    = 8'h00;
`endif

endmodule
